msk_aes_rnd_supplier: RTL and testbench

Randomness source for the masked 128-bit AES core: generates the four fresh-randomness buses (`rnd_bus0`, `rnd_bus2`, `rnd_bus3`, `rnd_bus4`) and their `pre_rnd*_valid` qualifiers, i.e. the producer end of the core's randomness interface. Internally it is a bank of seeded 32-bit xorshift generators loaded over a word-serial valid/ready seed port, followed by a warm-up phase and a free-running/stallable run phase. It sits beside the wired AES wrapper and is connected port-for-port to its randomness inputs.

---
 rtl/msk_aes_rnd_supplier.sv | 133 +++++++++++++
 tb/tb_msk_aes_rnd_supplier.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/msk_aes_rnd_supplier.sv
// Fresh-randomness producer for the masked AES core: a bank of seeded 32-bit xorshift generators
// loaded word-serially, warmed up, then stepped on demand; buses are driven straight from state.
module msk_aes_rnd_supplier #(
  parameter int unsigned d      = 2,
  parameter int unsigned WARMUP = 16,
  localparam int unsigned HPC2RND = d * (d - 1) / 2,
  localparam int unsigned W0 = 20 * 9 * HPC2RND,
  localparam int unsigned W2 = 20 * 3 * HPC2RND,
  localparam int unsigned W3 = 20 * 4 * HPC2RND,
  localparam int unsigned W4 = 20 * 18 * HPC2RND
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic [31:0]   seed_in,
  input  logic          seed_valid,
  output logic          seed_ready,
  input  logic          reseed,
  input  logic          enable,
  output logic [W0-1:0] rnd_bus0,
  output logic [W2-1:0] rnd_bus2,
  output logic [W3-1:0] rnd_bus3,
  output logic [W4-1:0] rnd_bus4,
  output logic          pre_rnd0_valid,
  output logic          pre_rnd2_valid,
  output logic          pre_rnd3_valid,
  output logic          pre_rnd4_valid
);

  localparam int unsigned W  = W0 + W2 + W3 + W4;
  localparam int unsigned G  = (W + 31) / 32;
  localparam int unsigned IW = (G > 1) ? $clog2(G) : 1;
  localparam int unsigned CW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  typedef enum logic [1:0] {LOAD, WARM, RUN} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   s_q [G];
  logic [31:0]   s_d [G];
  logic          step_all;
  logic          load_en;
  logic [31:0]   seed_fix;
  logic [W-1:0]  r;

  function automatic logic [31:0] xs_step(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  // An all-zero xorshift state is a fixed point, so a zero seed word is substituted.
  assign seed_fix = (seed_in == 32'h0) ? 32'h6B8B_4567 : seed_in;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    step_all = 1'b0;
    load_en  = 1'b0;
    case (state_q)
      LOAD: begin
        if (seed_valid) begin
          load_en = 1'b1;
          if (idx_q == IW'(G - 1)) begin
            idx_d   = '0;
            state_d = (WARMUP == 0) ? RUN : WARM;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      WARM: begin
        step_all = 1'b1;
        if (cnt_q == CW'(WARMUP - 1)) begin
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RUN:     step_all = enable;
      default: state_d = LOAD;
    endcase
    // Reseed overrides everything, including a coincident seed transfer.
    if (reseed) begin
      state_d  = LOAD;
      idx_d    = '0;
      cnt_d    = '0;
      step_all = 1'b0;
      load_en  = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < G; i++) begin
      s_d[i] = step_all ? xs_step(s_q[i]) : s_q[i];
      if (load_en && (idx_q == IW'(i))) s_d[i] = seed_fix;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= LOAD;
      idx_q   <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < G; i++) s_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < G; i++) s_q[i] <= s_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < W; i++) r[i] = s_q[i / 32][i % 32];
  end

  assign rnd_bus0 = r[W0-1:0];
  assign rnd_bus2 = r[W0+W2-1:W0];
  assign rnd_bus3 = r[W0+W2+W3-1:W0+W2];
  assign rnd_bus4 = r[W-1:W0+W2+W3];

  assign seed_ready     = (state_q == LOAD);
  assign pre_rnd0_valid = (state_q == RUN);
  assign pre_rnd2_valid = (state_q == RUN);
  assign pre_rnd3_valid = (state_q == RUN);
  assign pre_rnd4_valid = (state_q == RUN);

endmodule

// File: tb/tb_msk_aes_rnd_supplier.sv
// Bench for msk_aes_rnd_supplier: two instances (WARMUP=0 and WARMUP=16) share stimulus and are
// checked every cycle against a per-instance phase/array model of the generator bank.
module tb_msk_aes_rnd_supplier;

  localparam int G  = 22;
  localparam int W  = 680;
  localparam int P_LOAD = 0, P_WARM = 1, P_RUN = 2;
  localparam int WU [2] = '{0, 16};

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [31:0] seed_in = '0;
  logic        seed_valid = 1'b0;
  logic        reseed = 1'b0;
  logic        enable = 1'b0;

  logic [179:0] b0_0, b0_1;
  logic [59:0]  b2_0, b2_1;
  logic [79:0]  b3_0, b3_1;
  logic [359:0] b4_0, b4_1;
  logic v0_0, v2_0, v3_0, v4_0, rdy_0;
  logic v0_1, v2_1, v3_1, v4_1, rdy_1;

  int passed = 0;
  int total  = 0;
  bit zero_seen = 1'b0;

  logic [31:0] ms [2][G];
  int mph [2];
  int midx [2];
  int mleft [2];

  always #5 clk = ~clk;

  msk_aes_rnd_supplier #(.d(2), .WARMUP(0)) u_dut0 (
    .clk(clk), .nrst(nrst), .seed_in(seed_in), .seed_valid(seed_valid), .seed_ready(rdy_0),
    .reseed(reseed), .enable(enable), .rnd_bus0(b0_0), .rnd_bus2(b2_0), .rnd_bus3(b3_0),
    .rnd_bus4(b4_0), .pre_rnd0_valid(v0_0), .pre_rnd2_valid(v2_0), .pre_rnd3_valid(v3_0),
    .pre_rnd4_valid(v4_0));

  msk_aes_rnd_supplier #(.d(2), .WARMUP(16)) u_dut16 (
    .clk(clk), .nrst(nrst), .seed_in(seed_in), .seed_valid(seed_valid), .seed_ready(rdy_1),
    .reseed(reseed), .enable(enable), .rnd_bus0(b0_1), .rnd_bus2(b2_1), .rnd_bus3(b3_1),
    .rnd_bus4(b4_1), .pre_rnd0_valid(v0_1), .pre_rnd2_valid(v2_1), .pre_rnd3_valid(v3_1),
    .pre_rnd4_valid(v4_1));

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    return y ^ (y << 5);
  endfunction

  function automatic logic [W-1:0] model_r(input int m);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = ms[m][i / 32][i % 32];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [703:0] act, input logic [703:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  // Reference model: phase, load index and warm-up steps left, per instance.
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int m = 0; m < 2; m++) begin
        mph[m] <= P_LOAD; midx[m] <= 0; mleft[m] <= 0;
        for (int i = 0; i < G; i++) ms[m][i] <= '0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (reseed) begin
          mph[m] <= P_LOAD; midx[m] <= 0;
        end else if (mph[m] == P_LOAD) begin
          if (seed_valid) begin
            ms[m][midx[m]] <= (seed_in == 0) ? 32'h6B8B4567 : seed_in;
            if (midx[m] == G - 1) begin
              midx[m] <= 0;
              mph[m] <= (WU[m] == 0) ? P_RUN : P_WARM;
              mleft[m] <= WU[m];
            end else midx[m] <= midx[m] + 1;
          end
        end else if (mph[m] == P_WARM) begin
          for (int i = 0; i < G; i++) ms[m][i] <= xs(ms[m][i]);
          mleft[m] <= mleft[m] - 1;
          if (mleft[m] == 1) mph[m] <= P_RUN;
        end else if (enable) begin
          for (int i = 0; i < G; i++) ms[m][i] <= xs(ms[m][i]);
        end
      end
    end
  end

  task automatic cmp(input int m, input logic [W-1:0] r, input logic [3:0] v, input logic rdy);
    logic [W-1:0] e;
    e = model_r(m);
    chk($sformatf("valid[%0d]", m), v, {4{mph[m] == P_RUN}});
    chk($sformatf("seed_ready[%0d]", m), rdy, mph[m] == P_LOAD);
    chk($sformatf("bus0[%0d]", m), r[179:0], e[179:0]);
    chk($sformatf("bus2[%0d]", m), r[239:180], e[239:180]);
    chk($sformatf("bus3[%0d]", m), r[319:240], e[319:240]);
    chk($sformatf("bus4[%0d]", m), r[679:320], e[679:320]);
    if (v[0]) for (int i = 0; i < 21; i++) if (r[i*32 +: 32] == 32'h0) zero_seen = 1'b1;
  endtask

  always @(negedge clk) begin
    cmp(0, {b4_0, b3_0, b2_0, b0_0}, {v4_0, v3_0, v2_0, v0_0}, rdy_0);
    cmp(1, {b4_1, b3_1, b2_1, b0_1}, {v4_1, v3_1, v2_1, v0_1}, rdy_1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: all ones; 1: k+1; 2: random with word 3 zero.
  task automatic seed_all(input int mode, input bit gaps);
    for (int k = 0; k < G; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      seed_valid = 1'b1;
      seed_in = (mode == 0) ? 32'd1 : (mode == 1) ? 32'(k + 1) :
                (k == 3) ? 32'd0 : ($urandom | 32'd1);
      tick();
      seed_valid = 1'b0;
      seed_in = $urandom;
    end
  endtask

  initial begin
    logic [W-1:0] r0;
    int n;
    repeat (3) tick();
    nrst = 1'b1;
    repeat (10) tick();
    chk("idle_ready", rdy_1, 1'b1);
    chk("idle_bus4", b4_1, '0);

    // All-ones seed: WARMUP=0 instance runs immediately.
    seed_all(0, 1'b0);
    chk("w0_valid_after_seed", v0_0, 1'b1);
    r0 = {b4_0, b3_0, b2_0, b0_0};
    chk("w0_slice0_seed", r0[31:0], 32'h1);
    enable = 1'b1; tick(); enable = 1'b0;
    r0 = {b4_0, b3_0, b2_0, b0_0};
    chk("w0_slice0_step", r0[31:0], 32'h00042021);
    chk("w0_slice20_step", r0[671:640], 32'h00042021);
    tick();

    // Seeds k+1 with gaps; WARMUP=16 instance must go valid exactly 16 edges after last transfer.
    reseed = 1'b1; tick(); reseed = 1'b0;
    seed_all(1, 1'b1);
    n = 0;
    chk("w16_not_valid_yet", v0_1, 1'b0);
    while (!v0_1 && n < 100) begin tick(); n++; end
    chk("w16_warmup_latency", n, 16);

    foreach (WU[j]) begin end
    enable = 1'b1; tick();
    enable = 1'b0; tick(); tick();
    enable = 1'b1; tick();
    enable = 1'b0; tick();

    // Zero seed word at index 3, then a long run with ignored seed traffic.
    reseed = 1'b1; tick(); reseed = 1'b0;
    seed_all(2, 1'b0);
    r0 = {b4_0, b3_0, b2_0, b0_0};
    chk("w0_zero_seed_sub", r0[127:96], 32'h6B8B4567);
    for (int i = 0; i < 1000; i++) begin
      enable = 1'b1;
      seed_valid = $urandom_range(0, 1);
      seed_in = $urandom;
      tick();
    end
    seed_valid = 1'b0;
    chk("no_zero_slice", zero_seen, 1'b0);

    // Reseed in RUN with enable high, then reseed coincident with a seed transfer mid-load.
    reseed = 1'b1; tick(); reseed = 1'b0; enable = 1'b0;
    chk("reseed_run_valid", v0_0, 1'b0);
    chk("reseed_run_ready", rdy_0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      seed_valid = 1'b1; seed_in = $urandom; tick();
    end
    reseed = 1'b1; seed_in = 32'hDEAD_BEEF; tick();
    reseed = 1'b0; seed_valid = 1'b0;
    seed_all(1, 1'b1);
    repeat (20) tick();

    // Async reset pulse during warm-up.
    reseed = 1'b1; tick(); reseed = 1'b0;
    seed_all(2, 1'b0);
    repeat (5) tick();
    chk("w16_in_warm", v0_1, 1'b0);
    #2 nrst = 1'b0;
    #1;
    chk("arst_valid", {v4_1, v3_1, v2_1, v0_1}, 4'h0);
    chk("arst_ready", rdy_1, 1'b1);
    chk("arst_bus0", b0_1, '0);
    chk("arst_bus4", b4_1, '0);
    tick();
    nrst = 1'b1;
    repeat (3) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
